// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
package tristate_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } state_e;

  // $clog2 that never returns zero, so one-value counters still get a bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module tristate_bus_arbiter_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         onehot
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = 0; k < N; k++) begin
      int unsigned j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus: one-hot registered enables,
// a forced all-off turnaround gap between tenures, and an optional hold limit.
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         rel,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 bus_busy,
  output logic                 hold_expired
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned HW = clog2_min1(MAX_HOLD + 1);
  localparam int unsigned TW = clog2_min1(TURN_CYC + 1);
  localparam logic [HW-1:0] HoldLast = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [TW-1:0] TurnLast = TW'(TURN_CYC - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;
  logic          busy_q, hold_exp_q, hold_exp_d;

  logic          pick_any;
  logic [OW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic          rel_own, req_own, at_limit;

  tristate_bus_arbiter_rr_pick #(
    .N(N)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .any   (pick_any),
    .idx   (pick_idx),
    .onehot(pick_onehot)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    hold_exp_d = 1'b0;
    rel_own    = rel[owner_q];
    req_own    = req[owner_q];
    at_limit   = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast);

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d    = StGrant;
          gnt_d      = pick_onehot;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
        end
      end
      StGrant: begin
        if (rel_own || !req_own || at_limit) begin
          state_d    = StTurn;
          gnt_d      = '0;
          turn_cnt_d = '0;
          rr_ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
          // A voluntary end wins over the limit when both land together.
          hold_exp_d = at_limit && !rel_own && req_own;
        end else if (MAX_HOLD != 0) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      StTurn: begin
        if (turn_cnt_q == TurnLast) begin
          if (pick_any) begin
            state_d    = StGrant;
            gnt_d      = pick_onehot;
            owner_d    = pick_idx;
            hold_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      busy_q     <= 1'b0;
      hold_exp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      busy_q     <= (state_d != StIdle);
      hold_exp_q <= hold_exp_d;
    end
  end

  assign gnt          = gnt_q;
  assign owner        = owner_q;
  assign bus_busy     = busy_q;
  assign hold_expired = hold_exp_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench: dut (MAX_HOLD=4, TURN_CYC=1) and dut2 (MAX_HOLD=0, TURN_CYC=3).
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0, rel = '0, gnt;
  logic [1:0] owner;
  logic       bus_busy, hold_expired;
  logic [3:0] req2 = '0, rel2 = '0, gnt2;
  logic [1:0] owner2;
  logic       bus_busy2, hold_expired2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(4), .TURN_CYC(1)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .gnt(gnt), .owner(owner),
    .bus_busy(bus_busy), .hold_expired(hold_expired)
  );

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(0), .TURN_CYC(3)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .rel(rel2), .gnt(gnt2), .owner(owner2),
    .bus_busy(bus_busy2), .hold_expired(hold_expired2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Bus-safety monitor on both instances.
  always @(negedge clk) begin
    if (!rst) begin
      check("popcount_gnt", 32'($countones(gnt) <= 1), 32'd1);
      check("popcount_gnt2", 32'($countones(gnt2) <= 1), 32'd1);
    end
  end

  initial begin
    step();

    // 1: reset values, then single requester
    rst = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy", 32'(bus_busy), 32'h0);
    check("rst_hexp", 32'(hold_expired), 32'h0);
    rst = 1'b0;
    req = 4'b0001;
    step();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_owner", 32'(owner), 32'h0);
    check("t1_busy", 32'(bus_busy), 32'h1);

    // 2: release with no further requests
    rel = 4'b0001;
    req = 4'b0000;
    step();
    rel = 4'b0000;
    check("t2_turn_gnt", 32'(gnt), 32'h0);
    check("t2_turn_busy", 32'(bus_busy), 32'h1);
    check("t2_turn_hexp", 32'(hold_expired), 32'h0);
    step();
    check("t2_idle_gnt", 32'(gnt), 32'h0);
    check("t2_idle_busy", 32'(bus_busy), 32'h0);

    // 3: everyone requesting, hold limit rotates ownership
    pulse_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check($sformatf("t3_gnt_k%0d_c%0d", k, c), 32'(gnt), 32'(1 << k));
        check($sformatf("t3_own_k%0d_c%0d", k, c), 32'(owner), 32'(k));
        check($sformatf("t3_hexp_k%0d_c%0d", k, c), 32'(hold_expired), 32'h0);
      end
      step();
      check($sformatf("t3_gap_k%0d", k), 32'(gnt), 32'h0);
      check($sformatf("t3_gap_hexp_k%0d", k), 32'(hold_expired), 32'h1);
    end
    step();
    check("t3_wrap_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;

    // 4: owner 2 releases on its 2nd cycle, pointer wraps to 0
    pulse_reset();
    req = 4'b0100;
    step();
    check("t4_gnt_c1", 32'(gnt), 32'h4);
    check("t4_owner", 32'(owner), 32'h2);
    req = 4'b0101;
    step();
    check("t4_gnt_c2", 32'(gnt), 32'h4);
    rel = 4'b0100;
    step();
    rel = 4'b0000;
    check("t4_gap_gnt", 32'(gnt), 32'h0);
    check("t4_gap_hexp", 32'(hold_expired), 32'h0);
    step();
    check("t4_next_gnt", 32'(gnt), 32'h1);
    check("t4_next_owner", 32'(owner), 32'h0);
    req = 4'b0000;

    // 5: asynchronous reset mid-tenure
    pulse_reset();
    req = 4'b0010;
    step();
    check("t5_gnt", 32'(gnt), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_gnt", 32'(gnt), 32'h0);
    check("t5_async_busy", 32'(bus_busy), 32'h0);
    rst = 1'b0;
    step();
    check("t5_regrant_gnt", 32'(gnt), 32'h2);
    check("t5_regrant_owner", 32'(owner), 32'h1);
    req = 4'b0000;

    // 6: unlimited hold, 3-cycle turnaround
    pulse_reset();
    req2 = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("t6_gnt_c%0d", c), 32'(gnt2), 32'h1);
    end
    rel2 = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      rel2 = 4'b0000;
      check($sformatf("t6_gap_c%0d", c), 32'(gnt2), 32'h0);
      check($sformatf("t6_hexp_c%0d", c), 32'(hold_expired2), 32'h0);
    end
    step();
    check("t6_next_gnt", 32'(gnt2), 32'h2);
    check("t6_next_owner", 32'(owner2), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
